id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the RV32I pipeline, sitting between the fetch stage and execute. It decodes the fetched instruction and drives the register file read ports. It resolves operands through EX/MEM forwarding and detects load-use hazards. Results are registered into the ID/EX pipeline register with a valid/ready handshake. The register file already bypasses same-cycle writeback, so this block forwards only from EX and MEM.

## Interface
- `XLEN`, default 32: datapath width.
- `RADDR_W`, default 5: register address width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rdy`  in  1  global pause; when low, all state holds.
- `if_valid`  in  1  fetch offers an instruction.
- `if_pc`  in  XLEN  PC of the offered instruction.
- `if_inst`  in  32  offered instruction.
- `id_ready`  out  1  ID accepts this cycle; comb.
- `re1`/`re2`  out  1  register file read enables; comb.
- `raddr1`/`raddr2`  out  RADDR_W  register file read addresses (rs1, rs2); comb.
- `rdata1`/`rdata2`  in  XLEN  register file read data, same cycle.
- `ex_fwd_we`, `ex_fwd_waddr`, `ex_fwd_wdata`, `ex_fwd_is_load`  in  1/RADDR_W/XLEN/1  result currently in EX.
- `mem_fwd_we`, `mem_fwd_waddr`, `mem_fwd_wdata`  in  1/RADDR_W/XLEN  result currently in MEM.
- `flush`  in  1  redirect from EX; kills ID contents.
- `ex_ready`  in  1  EX accepts the ID/EX register.
- `ex_valid`  out  1  ID/EX register holds a valid op.
- `ex_pc`, `ex_op1`, `ex_op2`, `ex_imm`  out  XLEN  registered operands.
- `ex_alu_op`  out  5  ALU op code (shared defines).
- `ex_mem_op`  out  4  load/store kind (shared defines).
- `ex_rd`  out  RADDR_W  destination register.
- `ex_we`  out  1  writes `ex_rd`.

## Operation
- **Decode.** Decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - Any other opcode is a NOP: `ex_we`=0, `ex_mem_op`=NONE.
  - `re1`/`re2` are asserted only when the format uses rs1/rs2.
  - `ex_we` is forced to 0 when rd=x0.
- **Operand select, per source, first match wins:**
  1. Address x0 or read not enabled: 0.
  2. `ex_fwd_we` and `ex_fwd_waddr` equal the address: `ex_fwd_wdata`.
  3. `mem_fwd_we` and `mem_fwd_waddr` equal the address: `mem_fwd_wdata`.
  4. Otherwise `rdataN`.
- **op1/op2 mapping.** op1 = PC for AUIPC/JAL, 0 for LUI, else rs1 value. op2 = imm for immediate formats, else rs2 value. Stores carry rs2 in `ex_op2` and the offset in `ex_imm`.
- **Load-use hazard.** `if_valid` and `ex_fwd_is_load` and `ex_fwd_we`, with `ex_fwd_waddr` nonzero and equal to an enabled source. Response: `id_ready`=0 and a bubble is written if the output can advance.
- **Output register advance:** `adv` = `rdy` and (!`ex_valid` or `ex_ready`).
- **Fetch accept:** `id_ready` = `adv` and !hazard and !`flush`.
- **Priority on an edge with `rdy` high:**
  1. `flush`: `ex_valid`←0.
  2. Else `adv` and `id_ready` and `if_valid`: load the decoded op, `ex_valid`←1.
  3. Else `adv`: `ex_valid`←0 (bubble).
  4. Else hold.
- **Reset.** All outputs and registers go to 0, so `ex_valid`=0 and the ALU op reads as ADD/NOP. Reset overrides `rdy`. Reset mid-stall drops the held op.

## Timing
- Latency: accepted at edge N, visible on `ex_*` after edge N.
- Throughput: 1 op/cycle with no hazard.
- Load-use costs exactly one bubble. The next cycle the load is in MEM and its data is forwarded from MEM.
- `ex_ready`=0 with `ex_valid`=1: outputs hold stable and `id_ready`=0.
- `flush` together with a hazard or `ex_ready`=0: flush wins and `ex_valid`=0 next cycle.
- `rdy`=0: no state change, `id_ready`=0.

## Structure
- Shared `defines` include holds:
  - opcode constants;
  - ALU op codes (5-bit);
  - mem-op codes (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW);
  - `ZeroWord`, `RegAddrBus`, `RegBus`.
- Sub-module `id_decode`: purely combinational. It maps `inst` to `alu_op`, `mem_op`, `imm`, `rd`, `we`, `re1`, `re2`, `op1_sel`, `op2_sel`.
- `id_stage` holds the forwarding muxes, hazard logic and ID/EX register.

## Test plan
- **Reset.** `rst`=0 for 2 cycles with `if_valid`=1 → `ex_valid`=0, all `ex_*`=0. After release, `id_ready`=1.
- **ADDI with MEM forwarding.** ADDI x5,x1,-3 with `rdata1`=10 → next cycle `ex_op1`=10, `ex_op2`=0xFFFFFFFD, `ex_rd`=5, `ex_we`=1. Repeat with `mem_fwd` x1=7 → `ex_op1`=7.
- **EX over MEM priority.** ADD x3,x1,x2 with EX x1=0x11, MEM x1=0x22, `rdata2`=4 → `ex_op1`=0x11, `ex_op2`=4. Add EX to x0 with `wdata` 9 → `ex_op1` stays 0 for rs1=x0.
- **Load-use.** EX holds LW x4 with `ex_fwd_is_load`=1, ID has ADD x6,x4,x4 → `id_ready`=0, bubble `ex_valid`=0. Next cycle `mem_fwd` x4=0x55 → ADD issues with `op1`=`op2`=0x55.
- **Backpressure and rdy.** `ex_ready`=0 for 3 cycles → `ex_*` stable, `id_ready`=0. `rdy`=0 for 2 cycles mid-stream → no state change, no op lost or duplicated.
- **Flush during stall.** Flush during a load-use stall and `ex_ready`=0 → `ex_valid`=0 next cycle. JAL x1 at PC 0x100 → `ex_op1`=0x100, `ex_imm` = sign-extended offset, `ex_we`=1.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ============================================================================
// Module : id_stage_pkg
// Brief  : Shared decode constants for the RV32I decode stage
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_stage_pkg;

    localparam int          REG_ADDR_BUS = 5;
    localparam int          REG_BUS      = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ADD is zero so a reset ID/EX register reads as a NOP.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_BEQ  = 5'd10;
    localparam logic [4:0] ALU_BNE  = 5'd11;
    localparam logic [4:0] ALU_BLT  = 5'd12;
    localparam logic [4:0] ALU_BGE  = 5'd13;
    localparam logic [4:0] ALU_BLTU = 5'd14;
    localparam logic [4:0] ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_JAL  = 5'd16;
    localparam logic [4:0] ALU_JALR = 5'd17;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2} op1_sel_e;
    typedef enum logic       {OP2_RS2 = 1'b0, OP2_IMM = 1'b1} op2_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_decode.sv
// ============================================================================
// Module : id_decode
// Brief  : Combinational RV32I instruction field decoder
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_decode
    import id_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [31:0]        inst,
    output logic [4:0]         alu_op,
    output logic [3:0]         mem_op,
    output logic [XLEN-1:0]    imm,
    output logic [RADDR_W-1:0] rd,
    output logic               we,
    output logic               re1,
    output logic               re2,
    output op1_sel_e           op1_sel,
    output op2_sel_e           op2_sel
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
    logic        w_writes, w_f3_ok;

    assign w_opc   = inst[6:0];
    assign w_f3    = inst[14:12];
    assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_u = {inst[31:12], 12'b0};
    assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Reserved funct3 encodings of loads, stores and branches decode as NOPs.
    assign w_f3_ok = (w_opc == OPC_LOAD)   ? (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) :
                     (w_opc == OPC_STORE)  ? (w_f3 < 3'd3) :
                     (w_opc == OPC_BRANCH) ? (w_f3 != 3'd2 && w_f3 != 3'd3) : 1'b1;

    always_comb begin
        alu_op   = ALU_ADD;
        mem_op   = MEM_NONE;
        w_imm32  = 32'h0;
        w_writes = 1'b0;
        re1      = 1'b0;
        re2      = 1'b0;
        op1_sel  = OP1_RS1;
        op2_sel  = OP2_RS2;
        if (w_f3_ok) begin
            case (w_opc)
                OPC_LUI: begin
                    w_writes = 1'b1; op1_sel = OP1_ZERO; op2_sel = OP2_IMM; w_imm32 = w_imm_u;
                end
                OPC_AUIPC: begin
                    w_writes = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_IMM; w_imm32 = w_imm_u;
                end
                OPC_JAL: begin
                    w_writes = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_IMM; w_imm32 = w_imm_j;
                    alu_op = ALU_JAL;
                end
                OPC_JALR: begin
                    w_writes = 1'b1; re1 = 1'b1; op2_sel = OP2_IMM; w_imm32 = w_imm_i;
                    alu_op = ALU_JALR;
                end
                OPC_BRANCH: begin
                    re1 = 1'b1; re2 = 1'b1; w_imm32 = w_imm_b;
                    case (w_f3)
                        3'd0:    alu_op = ALU_BEQ;
                        3'd1:    alu_op = ALU_BNE;
                        3'd4:    alu_op = ALU_BLT;
                        3'd5:    alu_op = ALU_BGE;
                        3'd6:    alu_op = ALU_BLTU;
                        default: alu_op = ALU_BGEU;
                    endcase
                end
                OPC_LOAD: begin
                    w_writes = 1'b1; re1 = 1'b1; op2_sel = OP2_IMM; w_imm32 = w_imm_i;
                    case (w_f3)
                        3'd0:    mem_op = MEM_LB;
                        3'd1:    mem_op = MEM_LH;
                        3'd2:    mem_op = MEM_LW;
                        3'd4:    mem_op = MEM_LBU;
                        default: mem_op = MEM_LHU;
                    endcase
                end
                OPC_STORE: begin
                    re1 = 1'b1; re2 = 1'b1; w_imm32 = w_imm_s;
                    mem_op = MEM_SB + {2'b00, w_f3[1:0]};
                end
                OPC_OP_IMM, OPC_OP: begin
                    w_writes = 1'b1; re1 = 1'b1;
                    if (w_opc == OPC_OP_IMM) begin
                        op2_sel = OP2_IMM; w_imm32 = w_imm_i;
                    end else begin
                        re2 = 1'b1;
                    end
                    case (w_f3)
                        3'd0:    alu_op = (w_opc == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
                        3'd1:    alu_op = ALU_SLL;
                        3'd2:    alu_op = ALU_SLT;
                        3'd3:    alu_op = ALU_SLTU;
                        3'd4:    alu_op = ALU_XOR;
                        3'd5:    alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                        3'd6:    alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign imm = XLEN'($signed(w_imm32));
    assign rd  = w_writes ? RADDR_W'(inst[11:7]) : '0;
    assign we  = w_writes && (inst[11:7] != 5'd0);

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module : id_stage
// Brief  : RV32I decode stage: forwarding, load-use stall, ID/EX register
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               if_valid,
    input  logic [XLEN-1:0]    if_pc,
    input  logic [31:0]        if_inst,
    output logic               id_ready,
    output logic               re1,
    output logic               re2,
    output logic [RADDR_W-1:0] raddr1,
    output logic [RADDR_W-1:0] raddr2,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    input  logic               ex_fwd_we,
    input  logic [RADDR_W-1:0] ex_fwd_waddr,
    input  logic [XLEN-1:0]    ex_fwd_wdata,
    input  logic               ex_fwd_is_load,
    input  logic               mem_fwd_we,
    input  logic [RADDR_W-1:0] mem_fwd_waddr,
    input  logic [XLEN-1:0]    mem_fwd_wdata,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_alu_op,
    output logic [3:0]         ex_mem_op,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_we
);

    logic [4:0]         w_alu_op;
    logic [3:0]         w_mem_op;
    logic [XLEN-1:0]    w_imm, w_src1, w_src2, w_op1, w_op2;
    logic [RADDR_W-1:0] w_rd;
    logic               w_we, w_hazard, w_adv;
    op1_sel_e           w_op1_sel;
    op2_sel_e           w_op2_sel;

    id_decode #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_decode (
        .inst    (if_inst),
        .alu_op  (w_alu_op),
        .mem_op  (w_mem_op),
        .imm     (w_imm),
        .rd      (w_rd),
        .we      (w_we),
        .re1     (re1),
        .re2     (re2),
        .op1_sel (w_op1_sel),
        .op2_sel (w_op2_sel)
    );

    assign raddr1 = re1 ? RADDR_W'(if_inst[19:15]) : '0;
    assign raddr2 = re2 ? RADDR_W'(if_inst[24:20]) : '0;

    // The register file already bypasses writeback, so EX then MEM is enough.
    assign w_src1 = (!re1 || raddr1 == '0)                    ? '0 :
                    (ex_fwd_we  && ex_fwd_waddr  == raddr1)   ? ex_fwd_wdata :
                    (mem_fwd_we && mem_fwd_waddr == raddr1)   ? mem_fwd_wdata : rdata1;
    assign w_src2 = (!re2 || raddr2 == '0)                    ? '0 :
                    (ex_fwd_we  && ex_fwd_waddr  == raddr2)   ? ex_fwd_wdata :
                    (mem_fwd_we && mem_fwd_waddr == raddr2)   ? mem_fwd_wdata : rdata2;

    always_comb begin
        w_op1 = w_src1;
        case (w_op1_sel)
            OP1_PC:   w_op1 = if_pc;
            OP1_ZERO: w_op1 = '0;
            default:  ;
        endcase
    end

    assign w_op2 = (w_op2_sel == OP2_IMM) ? w_imm : w_src2;

    assign w_hazard = if_valid && ex_fwd_is_load && ex_fwd_we && (ex_fwd_waddr != '0) &&
                      ((re1 && ex_fwd_waddr == raddr1) || (re2 && ex_fwd_waddr == raddr2));
    assign w_adv    = rdy && (!ex_valid || ex_ready);
    assign id_ready = w_adv && !w_hazard && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_imm    <= '0;
            ex_alu_op <= '0;
            ex_mem_op <= '0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (id_ready && if_valid) begin
                ex_valid  <= 1'b1;
                ex_pc     <= if_pc;
                ex_op1    <= w_op1;
                ex_op2    <= w_op2;
                ex_imm    <= w_imm;
                ex_alu_op <= w_alu_op;
                ex_mem_op <= w_mem_op;
                ex_rd     <= w_rd;
                ex_we     <= w_we;
            end else if (w_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a behavioural reference model.
`default_nettype none

module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, if_valid, id_ready, re1, re2;
    logic [31:0] if_pc, if_inst, rdata1, rdata2;
    logic [4:0]  raddr1, raddr2;
    logic        ex_fwd_we, ex_fwd_is_load, mem_fwd_we, flush, ex_ready;
    logic [4:0]  ex_fwd_waddr, mem_fwd_waddr;
    logic [31:0] ex_fwd_wdata, mem_fwd_wdata;
    logic        ex_valid, ex_we;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_alu_op, ex_rd;
    logic [3:0]  ex_mem_op;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_waddr(ex_fwd_waddr), .ex_fwd_wdata(ex_fwd_wdata),
        .ex_fwd_is_load(ex_fwd_is_load),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
        .ex_mem_op(ex_mem_op), .ex_rd(ex_rd), .ex_we(ex_we)
    );

    int checks = 0;
    int errors = 0;

    // Expected contents of the ID/EX register.
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_op1, m_op2, m_imm;
    logic [4:0]  m_alu, m_rd;
    logic [3:0]  m_mem;

    typedef struct {
        logic        u1, u2, wr, op2imm;
        int          op1k;     // 0 = rs1 value, 1 = pc, 2 = zero
        logic [4:0]  alu;
        logic [3:0]  mem;
        logic [31:0] imm;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] inst);
        dec_t        d;
        logic [2:0]  f3 = inst[14:12];
        logic [31:0] si = inst;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [4:0]  alu_tab [8];
        logic [4:0]  br_tab  [8];
        logic [3:0]  ld_tab  [8];
        alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_tab  = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        ld_tab  = '{MEM_LB, MEM_LH, MEM_LW, MEM_NONE, MEM_LBU, MEM_LHU, MEM_NONE, MEM_NONE};
        i_imm = 32'($signed(si) >>> 20);
        s_imm = (32'($signed(si) >>> 25) << 5) | 32'(inst[11:7]);
        b_imm = (32'($signed(si) >>> 31) << 12) | (32'(inst[7]) << 11) |
                (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        u_imm = inst & 32'hFFFF_F000;
        j_imm = (32'($signed(si) >>> 31) << 20) | (32'(inst[19:12]) << 12) |
                (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        d = '{u1: 1'b0, u2: 1'b0, wr: 1'b0, op2imm: 1'b0, op1k: 0,
              alu: ALU_ADD, mem: MEM_NONE, imm: 32'h0};
        case (inst[6:0])
            OPC_LUI:   begin d.wr = 1; d.op1k = 2; d.op2imm = 1; d.imm = u_imm; end
            OPC_AUIPC: begin d.wr = 1; d.op1k = 1; d.op2imm = 1; d.imm = u_imm; end
            OPC_JAL:   begin d.wr = 1; d.op1k = 1; d.op2imm = 1; d.imm = j_imm; d.alu = ALU_JAL; end
            OPC_JALR:  begin d.wr = 1; d.u1 = 1; d.op2imm = 1; d.imm = i_imm; d.alu = ALU_JALR; end
            OPC_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
                d.u1 = 1; d.u2 = 1; d.imm = b_imm; d.alu = br_tab[f3];
            end
            OPC_LOAD: if (ld_tab[f3] != MEM_NONE) begin
                d.wr = 1; d.u1 = 1; d.op2imm = 1; d.imm = i_imm; d.mem = ld_tab[f3];
            end
            OPC_STORE: if (f3 < 3'd3) begin
                d.u1 = 1; d.u2 = 1; d.imm = s_imm; d.mem = MEM_SB + 4'(f3);
            end
            OPC_OP_IMM: begin
                d.wr = 1; d.u1 = 1; d.op2imm = 1; d.imm = i_imm; d.alu = alu_tab[f3];
                if (f3 == 3'd5 && inst[30]) d.alu = ALU_SRA;
            end
            OPC_OP: begin
                d.wr = 1; d.u1 = 1; d.u2 = 1; d.alu = alu_tab[f3];
                if (f3 == 3'd0 && inst[30]) d.alu = ALU_SUB;
                if (f3 == 3'd5 && inst[30]) d.alu = ALU_SRA;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] ref_src(input logic en, input logic [4:0] a, input logic [31:0] rf);
        if (!en || a == 5'd0)                   return 32'h0;
        if (ex_fwd_we && ex_fwd_waddr == a)     return ex_fwd_wdata;
        if (mem_fwd_we && mem_fwd_waddr == a)   return mem_fwd_wdata;
        return rf;
    endfunction

    // One clock: check the comb outputs for the current inputs, advance the model, check ex_*.
    task automatic step();
        dec_t        d;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2;
        logic        haz, adv, exp_ready;
        #1;
        d   = ref_decode(if_inst);
        rs1 = if_inst[19:15];
        rs2 = if_inst[24:20];
        rd  = if_inst[11:7];
        v1  = ref_src(d.u1, rs1, rdata1);
        v2  = ref_src(d.u2, rs2, rdata2);
        haz = if_valid && ex_fwd_is_load && ex_fwd_we && ex_fwd_waddr != 5'd0 &&
              ((d.u1 && ex_fwd_waddr == rs1) || (d.u2 && ex_fwd_waddr == rs2));
        adv = rdy && (!m_valid || ex_ready);
        exp_ready = adv && !haz && !flush;
        chk("id_ready", 32'(id_ready), 32'(exp_ready));
        chk("re1", 32'(re1), 32'(d.u1));
        chk("re2", 32'(re2), 32'(d.u2));
        if (d.u1) chk("raddr1", 32'(raddr1), 32'(rs1));
        if (d.u2) chk("raddr2", 32'(raddr2), 32'(rs2));
        if (!rst) begin
            {m_valid, m_we, m_pc, m_op1, m_op2, m_imm, m_alu, m_rd, m_mem} = '0;
        end else if (rdy) begin
            if (flush) m_valid = 1'b0;
            else if (exp_ready && if_valid) begin
                m_valid = 1'b1;
                m_pc    = if_pc;
                m_op1   = (d.op1k == 1) ? if_pc : (d.op1k == 2) ? 32'h0 : v1;
                m_op2   = d.op2imm ? d.imm : v2;
                m_imm   = d.imm;
                m_alu   = d.alu;
                m_mem   = d.mem;
                m_rd    = d.wr ? rd : 5'd0;
                m_we    = d.wr && rd != 5'd0;
            end else if (adv) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_op1", ex_op1, m_op1);
        chk("ex_op2", ex_op2, m_op2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m_alu));
        chk("ex_mem_op", 32'(ex_mem_op), 32'(m_mem));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("ex_we", 32'(ex_we), 32'(m_we));
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] inst = $urandom;
        logic [6:0]  opcs [11];
        logic [2:0]  ld_f3 [5];
        logic [2:0]  br_f3 [6];
        int          k = $urandom_range(0, 10);
        opcs  = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                  OPC_OP_IMM, OPC_OP, 7'b0001111, 7'b1110011};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        inst[6:0]   = opcs[k];
        inst[11:7]  = 5'($urandom_range(0, 3));
        inst[19:15] = 5'($urandom_range(0, 3));
        inst[24:20] = 5'($urandom_range(0, 3));
        if (opcs[k] == OPC_LOAD)   inst[14:12] = ld_f3[$urandom_range(0, 4)];
        if (opcs[k] == OPC_BRANCH) inst[14:12] = br_f3[$urandom_range(0, 5)];
        if (opcs[k] == OPC_STORE)  inst[14:12] = 3'($urandom_range(0, 2));
        return inst;
    endfunction

    task automatic idle();
        rst = 1; rdy = 1; if_valid = 0; if_pc = 32'h0; if_inst = 32'h0;
        rdata1 = 0; rdata2 = 0; flush = 0; ex_ready = 1;
        ex_fwd_we = 0; ex_fwd_waddr = 0; ex_fwd_wdata = 0; ex_fwd_is_load = 0;
        mem_fwd_we = 0; mem_fwd_waddr = 0; mem_fwd_wdata = 0;
    endtask

    initial begin
        {m_valid, m_we, m_pc, m_op1, m_op2, m_imm, m_alu, m_rd, m_mem} = '0;
        idle();
        // Reset with a valid instruction offered.
        rst = 0; if_valid = 1; if_inst = enc_i(12'hFFD, 5'd1, 3'd0, 5'd5); if_pc = 32'h40;
        step(); step();
        chk("reset_ex_valid", 32'(ex_valid), 32'h0);
        chk("reset_ex_op2", ex_op2, 32'h0);
        rst = 1; if_valid = 0; #1;
        chk("post_reset_id_ready", 32'(id_ready), 32'h1);

        // ADDI x5,x1,-3 from the register file, then via MEM forwarding.
        if_valid = 1; rdata1 = 32'd10;
        step();
        chk("addi_op1", ex_op1, 32'd10);
        chk("addi_op2", ex_op2, 32'hFFFF_FFFD);
        chk("addi_rd", 32'(ex_rd), 32'd5);
        chk("addi_we", 32'(ex_we), 32'd1);
        mem_fwd_we = 1; mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'd7;
        step();
        chk("addi_memfwd_op1", ex_op1, 32'd7);

        // ADD x3,x1,x2: EX wins over MEM; x0 never forwards.
        if_inst = enc_r(7'd0, 5'd2, 5'd1, 5'd3); rdata2 = 32'd4;
        ex_fwd_we = 1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'h11;
        mem_fwd_wdata = 32'h22;
        step();
        chk("exfwd_op1", ex_op1, 32'h11);
        chk("exfwd_op2", ex_op2, 32'd4);
        if_inst = enc_r(7'd0, 5'd2, 5'd0, 5'd3); ex_fwd_waddr = 5'd0; ex_fwd_wdata = 32'd9;
        step();
        chk("x0_op1", ex_op1, 32'h0);

        // Load-use: one bubble, then MEM supplies the loaded value.
        idle();
        if_valid = 1; if_pc = 32'h80; if_inst = enc_r(7'd0, 5'd4, 5'd4, 5'd6);
        ex_fwd_we = 1; ex_fwd_waddr = 5'd4; ex_fwd_is_load = 1; ex_fwd_wdata = 32'hDEAD;
        #1;
        chk("loaduse_id_ready", 32'(id_ready), 32'h0);
        step();
        chk("loaduse_bubble", 32'(ex_valid), 32'h0);
        ex_fwd_we = 0; ex_fwd_is_load = 0;
        mem_fwd_we = 1; mem_fwd_waddr = 5'd4; mem_fwd_wdata = 32'h55;
        step();
        chk("loaduse_valid", 32'(ex_valid), 32'h1);
        chk("loaduse_op1", ex_op1, 32'h55);
        chk("loaduse_op2", ex_op2, 32'h55);

        // Backpressure for three cycles, then release.
        idle();
        if_valid = 1; if_inst = enc_i(12'h001, 5'd0, 3'd0, 5'd7);
        step();
        ex_ready = 0; if_inst = enc_i(12'h002, 5'd0, 3'd0, 5'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_rd", 32'(ex_rd), 32'd7);
        end
        ex_ready = 1;
        step();
        chk("stall_release_rd", 32'(ex_rd), 32'd8);
        // rdy low: nothing moves, the next op issues exactly once.
        rdy = 0; if_inst = enc_i(12'h003, 5'd0, 3'd0, 5'd9);
        step(); step();
        chk("rdy_hold_rd", 32'(ex_rd), 32'd8);
        chk("rdy_hold_op2", ex_op2, 32'd2);
        rdy = 1;
        step();
        chk("rdy_resume_rd", 32'(ex_rd), 32'd9);
        if_valid = 0;
        step();
        chk("no_duplicate", 32'(ex_valid), 32'h0);

        // Flush during a load-use stall with EX backpressure.
        if_valid = 1; if_inst = enc_i(12'h004, 5'd0, 3'd0, 5'd10);
        step();
        ex_ready = 0; flush = 1; if_inst = enc_r(7'd0, 5'd4, 5'd4, 5'd6);
        ex_fwd_we = 1; ex_fwd_waddr = 5'd4; ex_fwd_is_load = 1;
        step();
        chk("flush_stall", 32'(ex_valid), 32'h0);

        // JAL x1,-8 at PC 0x100.
        idle();
        if_valid = 1; if_pc = 32'h100;
        if_inst = {1'b1, 10'h3FC, 1'b1, 8'hFF, 5'd1, OPC_JAL};
        step();
        chk("jal_op1", ex_op1, 32'h100);
        chk("jal_imm", ex_imm, 32'hFFFF_FFF8);
        chk("jal_we", 32'(ex_we), 32'h1);

        // Reset during a stall discards the held op.
        ex_ready = 0; rst = 0;
        step();
        chk("reset_mid_stall", 32'(ex_valid), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 63) != 0);
            rdy            = ($urandom_range(0, 7) != 0);
            if_valid       = ($urandom_range(0, 3) != 0);
            if_pc          = $urandom & 32'hFFFF_FFFC;
            if_inst        = rand_inst();
            rdata1         = $urandom;
            rdata2         = $urandom;
            ex_fwd_we      = 1'($urandom_range(0, 1));
            ex_fwd_waddr   = 5'($urandom_range(0, 3));
            ex_fwd_wdata   = $urandom;
            ex_fwd_is_load = ($urandom_range(0, 2) == 0);
            mem_fwd_we     = 1'($urandom_range(0, 1));
            mem_fwd_waddr  = 5'($urandom_range(0, 3));
            mem_fwd_wdata  = $urandom;
            flush          = ($urandom_range(0, 15) == 0);
            ex_ready       = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
